// File: rtl/bp_io_mmio_responder.sv
// Uncached I/O command responder: decodes one io_cmd at a time against a small register
// window (scratch, putchar, finish, cycle counter) and returns exactly one io_resp per command.
module bp_io_mmio_responder #(
    parameter int                       paddr_width_p = 40,
    parameter int                       data_width_p  = 64,
    parameter logic [paddr_width_p-1:0] base_addr_p   = 40'h00_0010_0000
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [3:0]               io_cmd_type_i,
    input  logic [paddr_width_p-1:0] io_cmd_addr_i,
    input  logic [2:0]               io_cmd_size_i,
    input  logic [data_width_p-1:0]  io_cmd_data_i,
    input  logic                     io_cmd_v_i,
    output logic                     io_cmd_ready_o,
    output logic [3:0]               io_resp_type_o,
    output logic [paddr_width_p-1:0] io_resp_addr_o,
    output logic [2:0]               io_resp_size_o,
    output logic [data_width_p-1:0]  io_resp_data_o,
    output logic                     io_resp_v_o,
    input  logic                     io_resp_yumi_i,
    output logic [7:0]               putchar_o,
    output logic                     putchar_v_o,
    input  logic                     putchar_ready_i,
    output logic                     finish_o,
    output logic [7:0]               finish_code_o,
    output logic                     decode_err_o
);

    localparam logic [3:0]              uc_wr_c  = 4'd3;
    localparam logic [data_width_p-1:0] one_c    = data_width_p'(1);
    localparam logic [12:0]             off_s0_c = 13'h0000;
    localparam logic [12:0]             off_s1_c = 13'h0001;
    localparam logic [12:0]             off_pc_c = 13'h0200;
    localparam logic [12:0]             off_fn_c = 13'h0400;
    localparam logic [12:0]             off_ct_c = 13'h0600;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUTC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                     state_r;
    logic                       cmd_ready_r;
    logic [3:0]                 resp_type_r;
    logic [paddr_width_p-1:0]   resp_addr_r;
    logic [2:0]                 resp_size_r;
    logic [data_width_p-1:0]    resp_data_r;
    logic                       resp_v_r;
    logic [7:0]                 putchar_r;
    logic                       putchar_v_r;
    logic                       finish_r;
    logic [7:0]                 finish_code_r;
    logic                       decode_err_r;
    logic [data_width_p-1:0]    scratch0_r;
    logic [data_width_p-1:0]    scratch1_r;
    logic [data_width_p-1:0]    cycle_r;

    logic                       is_wr_s;
    logic                       hit_s;
    logic [12:0]                off_s;
    logic                       sel_s0_s;
    logic                       sel_s1_s;
    logic                       sel_pc_s;
    logic                       sel_fn_s;
    logic                       sel_ct_s;
    logic                       err_s;
    logic [data_width_p-1:0]    mask_s;
    logic [data_width_p-1:0]    rd_raw_s;
    logic [data_width_p-1:0]    rd_data_s;

    // Byte-lane mask covering 2^size low bytes; sizes above 3 behave as 3.
    function automatic logic [data_width_p-1:0] byte_mask(input logic [2:0] size);
        logic [2:0]              eff;
        int                      nbytes;
        logic [data_width_p-1:0] m;
        eff    = (size > 3'd3) ? 3'd3 : size;
        nbytes = int'(32'd1 << eff);
        m      = '0;
        for (int i = 0; i < data_width_p / 8; i++) begin
            if (i < nbytes) begin
                m[i*8 +: 8] = 8'hFF;
            end else begin
                m[i*8 +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

    // Merge a write into a register: masked bytes replaced, upper bytes kept.
    function automatic logic [data_width_p-1:0] merge_wr(
        input logic [data_width_p-1:0] old_v,
        input logic [data_width_p-1:0] new_v,
        input logic [data_width_p-1:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Address decode and read-data selection for the command currently presented.
    always_comb begin
        is_wr_s  = (io_cmd_type_i == uc_wr_c);
        hit_s    = (io_cmd_addr_i[paddr_width_p-1:16] == base_addr_p[paddr_width_p-1:16]);
        off_s    = io_cmd_addr_i[15:3];
        mask_s   = byte_mask(io_cmd_size_i);
        sel_s0_s = 1'b0;
        sel_s1_s = 1'b0;
        sel_pc_s = 1'b0;
        sel_fn_s = 1'b0;
        sel_ct_s = 1'b0;
        rd_raw_s = '0;
        if (hit_s) begin
            case (off_s)
                off_s0_c: begin sel_s0_s = 1'b1; rd_raw_s = scratch0_r; end
                off_s1_c: begin sel_s1_s = 1'b1; rd_raw_s = scratch1_r; end
                off_pc_c: begin sel_pc_s = 1'b1; rd_raw_s = '0; end
                off_fn_c: begin sel_fn_s = 1'b1; rd_raw_s = {{(data_width_p-1){1'b0}}, finish_r}; end
                off_ct_c: begin sel_ct_s = 1'b1; rd_raw_s = cycle_r; end
                default:  begin rd_raw_s = '0; end
            endcase
        end else begin
            rd_raw_s = '0;
        end
        err_s     = ~(sel_s0_s | sel_s1_s | sel_pc_s | sel_fn_s | sel_ct_s);
        rd_data_s = rd_raw_s & mask_s;
    end

    // Command FSM, register file, cycle counter and all registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= ST_IDLE;
            cmd_ready_r   <= 1'b0;
            resp_type_r   <= 4'd0;
            resp_addr_r   <= '0;
            resp_size_r   <= 3'd0;
            resp_data_r   <= '0;
            resp_v_r      <= 1'b0;
            putchar_r     <= 8'd0;
            putchar_v_r   <= 1'b0;
            finish_r      <= 1'b0;
            finish_code_r <= 8'd0;
            decode_err_r  <= 1'b0;
            scratch0_r    <= '0;
            scratch1_r    <= '0;
            cycle_r       <= '0;
        end else begin
            cycle_r <= cycle_r + one_c;
            case (state_r)
                ST_IDLE: begin
                    if (io_cmd_v_i && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        resp_type_r <= io_cmd_type_i;
                        resp_addr_r <= io_cmd_addr_i;
                        resp_size_r <= io_cmd_size_i;
                        if (err_s) begin
                            decode_err_r <= 1'b1;
                        end
                        if (is_wr_s && sel_pc_s) begin
                            resp_data_r <= '0;
                            putchar_r   <= io_cmd_data_i[7:0];
                            putchar_v_r <= 1'b1;
                            state_r     <= ST_PUTC;
                        end else begin
                            if (is_wr_s) begin
                                resp_data_r <= '0;
                                if (sel_s0_s) begin
                                    scratch0_r <= merge_wr(scratch0_r, io_cmd_data_i, mask_s);
                                end
                                if (sel_s1_s) begin
                                    scratch1_r <= merge_wr(scratch1_r, io_cmd_data_i, mask_s);
                                end
                                if (sel_fn_s) begin
                                    finish_r      <= 1'b1;
                                    finish_code_r <= io_cmd_data_i[7:0];
                                end
                            end else begin
                                resp_data_r <= rd_data_s;
                            end
                            resp_v_r <= 1'b1;
                            state_r  <= ST_RESP;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_PUTC: begin
                    if (putchar_ready_i) begin
                        putchar_v_r <= 1'b0;
                        resp_v_r    <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (io_resp_yumi_i) begin
                        resp_v_r    <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b0;
                    resp_v_r    <= 1'b0;
                    putchar_v_r <= 1'b0;
                end
            endcase
        end
    end

    assign io_cmd_ready_o = cmd_ready_r;
    assign io_resp_type_o = resp_type_r;
    assign io_resp_addr_o = resp_addr_r;
    assign io_resp_size_o = resp_size_r;
    assign io_resp_data_o = resp_data_r;
    assign io_resp_v_o    = resp_v_r;
    assign putchar_o      = putchar_r;
    assign putchar_v_o    = putchar_v_r;
    assign finish_o       = finish_r;
    assign finish_code_o  = finish_code_r;
    assign decode_err_o   = decode_err_r;

endmodule

// File: tb/tb_bp_io_mmio_responder.sv
// Directed bench for bp_io_mmio_responder: hand-computed expected values, sampled on the falling edge.
module tb_bp_io_mmio_responder;

    localparam logic [39:0] base_c = 40'h00_0010_0000;
    localparam logic [3:0]  rd_c   = 4'd2;
    localparam logic [3:0]  wr_c   = 4'd3;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [3:0]  io_cmd_type_i = 4'd0;
    logic [39:0] io_cmd_addr_i = 40'd0;
    logic [2:0]  io_cmd_size_i = 3'd0;
    logic [63:0] io_cmd_data_i = 64'd0;
    logic        io_cmd_v_i = 1'b0;
    logic        io_cmd_ready_o;
    logic [3:0]  io_resp_type_o;
    logic [39:0] io_resp_addr_o;
    logic [2:0]  io_resp_size_o;
    logic [63:0] io_resp_data_o;
    logic        io_resp_v_o;
    logic        io_resp_yumi_i = 1'b0;
    logic [7:0]  putchar_o;
    logic        putchar_v_o;
    logic        putchar_ready_i = 1'b0;
    logic        finish_o;
    logic [7:0]  finish_code_o;
    logic        decode_err_o;

    int checks = 0;
    int errors = 0;

    bp_io_mmio_responder dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .io_cmd_type_i   (io_cmd_type_i),
        .io_cmd_addr_i   (io_cmd_addr_i),
        .io_cmd_size_i   (io_cmd_size_i),
        .io_cmd_data_i   (io_cmd_data_i),
        .io_cmd_v_i      (io_cmd_v_i),
        .io_cmd_ready_o  (io_cmd_ready_o),
        .io_resp_type_o  (io_resp_type_o),
        .io_resp_addr_o  (io_resp_addr_o),
        .io_resp_size_o  (io_resp_size_o),
        .io_resp_data_o  (io_resp_data_o),
        .io_resp_v_o     (io_resp_v_o),
        .io_resp_yumi_i  (io_resp_yumi_i),
        .putchar_o       (putchar_o),
        .putchar_v_o     (putchar_v_o),
        .putchar_ready_i (putchar_ready_i),
        .finish_o        (finish_o),
        .finish_code_o   (finish_code_o),
        .decode_err_o    (decode_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one non-putchar command from a falling edge, expect the response one cycle later, consume it.
    task automatic do_cmd(input string tag, input logic [3:0] t, input logic [39:0] a,
                          input logic [2:0] s, input logic [63:0] d, output logic [63:0] rd);
        int n;
        n = 0;
        io_cmd_type_i = t;
        io_cmd_addr_i = a;
        io_cmd_size_i = s;
        io_cmd_data_i = d;
        io_cmd_v_i    = 1'b1;
        while (!io_cmd_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check_val({tag, "_ready"}, {63'd0, io_cmd_ready_o}, 64'd1);
        @(negedge clk_i);
        io_cmd_v_i = 1'b0;
        check_val({tag, "_lat"}, {63'd0, io_resp_v_o}, 64'd1);
        rd = io_resp_data_o;
        io_resp_yumi_i = 1'b1;
        @(negedge clk_i);
        io_resp_yumi_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        logic [63:0] c1;
        logic [63:0] c2;

        // Reset state
        repeat (3) @(negedge clk_i);
        check_val("rst_ready", {63'd0, io_cmd_ready_o}, 64'd0);
        check_val("rst_resp_v", {63'd0, io_resp_v_o}, 64'd0);
        check_val("rst_flags", {60'd0, putchar_v_o, finish_o, decode_err_o, 1'b0}, 64'd0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check_val("rel_ready", {63'd0, io_cmd_ready_o}, 64'd1);

        // 1: full-width write and readback
        do_cmd("t1_wr", wr_c, base_c, 3'd3, 64'h1122_3344_5566_7788, rd);
        check_val("t1_wr_data", rd, 64'd0);
        do_cmd("t1_rd", rd_c, base_c, 3'd3, 64'd0, rd);
        check_val("t1_rd_data", rd, 64'h1122_3344_5566_7788);

        // 2: partial writes keep upper bytes, partial reads zero-extend
        do_cmd("t2_ones", wr_c, base_c, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, rd);
        do_cmd("t2_wr16", wr_c, base_c, 3'd1, 64'h1234_0000_0000_ABCD, rd);
        do_cmd("t2_rd64", rd_c, base_c, 3'd3, 64'd0, rd);
        check_val("t2_rd64_data", rd, 64'hFFFF_FFFF_FFFF_ABCD);
        do_cmd("t2_rd8", rd_c, base_c + 40'h4, 3'd0, 64'd0, rd);
        check_val("t2_rd8_data", rd, 64'h0000_0000_0000_00CD);
        do_cmd("t2_rd_sz7", rd_c, base_c, 3'd7, 64'd0, rd);
        check_val("t2_rd_sz7_data", rd, 64'hFFFF_FFFF_FFFF_ABCD);
        do_cmd("t2_s1wr", wr_c, base_c + 40'h8, 3'd2, 64'hDEAD_BEEF_CAFE_F00D, rd);
        do_cmd("t2_s1rd", 4'd0, base_c + 40'h8, 3'd3, 64'd0, rd);
        check_val("t2_s1rd_data", rd, 64'h0000_0000_CAFE_F00D);

        // 3: putchar with stalled sink
        io_cmd_type_i = wr_c;
        io_cmd_addr_i = base_c + 40'h1000;
        io_cmd_size_i = 3'd0;
        io_cmd_data_i = 64'h41;
        io_cmd_v_i    = 1'b1;
        @(negedge clk_i);
        io_cmd_v_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("t3_pc_v", {63'd0, putchar_v_o}, 64'd1);
            check_val("t3_pc_char", {56'd0, putchar_o}, 64'h41);
            check_val("t3_ready", {63'd0, io_cmd_ready_o}, 64'd0);
            check_val("t3_resp_v", {63'd0, io_resp_v_o}, 64'd0);
            if (i == 4) begin
                putchar_ready_i = 1'b1;
            end
            @(negedge clk_i);
        end
        putchar_ready_i = 1'b0;
        check_val("t3_resp_after", {63'd0, io_resp_v_o}, 64'd1);
        check_val("t3_pc_drop", {63'd0, putchar_v_o}, 64'd0);
        io_resp_yumi_i = 1'b1;
        @(negedge clk_i);
        io_resp_yumi_i = 1'b0;

        // 4: consumer stall holds the response and blocks a second command
        io_cmd_type_i = wr_c;
        io_cmd_addr_i = base_c;
        io_cmd_size_i = 3'd3;
        io_cmd_data_i = 64'h0BAD_F00D_1234_5678;
        io_cmd_v_i    = 1'b1;
        @(negedge clk_i);
        io_cmd_type_i = rd_c;
        io_cmd_addr_i = base_c + 40'h8;
        io_cmd_data_i = 64'd0;
        for (int i = 0; i < 10; i++) begin
            check_val("t4_resp_v", {63'd0, io_resp_v_o}, 64'd1);
            check_val("t4_resp_type", {60'd0, io_resp_type_o}, {60'd0, wr_c});
            check_val("t4_resp_addr", {24'd0, io_resp_addr_o}, {24'd0, base_c});
            check_val("t4_ready", {63'd0, io_cmd_ready_o}, 64'd0);
            if (i < 9) begin
                @(negedge clk_i);
            end
        end
        io_resp_yumi_i = 1'b1;
        @(negedge clk_i);
        io_resp_yumi_i = 1'b0;
        check_val("t4_ready_after", {63'd0, io_cmd_ready_o}, 64'd1);
        check_val("t4_resp_gone", {63'd0, io_resp_v_o}, 64'd0);
        @(negedge clk_i);
        io_cmd_v_i = 1'b0;
        check_val("t4_second_v", {63'd0, io_resp_v_o}, 64'd1);
        check_val("t4_second_addr", {24'd0, io_resp_addr_o}, {24'd0, base_c + 40'h8});
        check_val("t4_second_data", io_resp_data_o, 64'h0000_0000_CAFE_F00D);
        io_resp_yumi_i = 1'b1;
        @(negedge clk_i);
        io_resp_yumi_i = 1'b0;

        // 5: finish register and decode errors
        do_cmd("t5_fin0", wr_c, base_c + 40'h2000, 3'd3, 64'h0, rd);
        check_val("t5_finish", {63'd0, finish_o}, 64'd1);
        check_val("t5_code0", {56'd0, finish_code_o}, 64'd0);
        check_val("t5_err_clean", {63'd0, decode_err_o}, 64'd0);
        do_cmd("t5_fin5a", wr_c, base_c + 40'h2000, 3'd0, 64'h5A, rd);
        check_val("t5_code5a", {56'd0, finish_code_o}, 64'h5A);
        do_cmd("t5_finrd", rd_c, base_c + 40'h2000, 3'd3, 64'd0, rd);
        check_val("t5_finrd_data", rd, 64'd1);
        do_cmd("t5_pcrd", rd_c, base_c + 40'h1000, 3'd3, 64'd0, rd);
        check_val("t5_pcrd_data", rd, 64'd0);
        check_val("t5_err_still0", {63'd0, decode_err_o}, 64'd0);
        do_cmd("t5_unmap", rd_c, base_c + 40'h4000, 3'd3, 64'd0, rd);
        check_val("t5_unmap_data", rd, 64'd0);
        check_val("t5_err_set", {63'd0, decode_err_o}, 64'd1);
        do_cmd("t5_miss", rd_c, base_c + 40'h1_0000, 3'd3, 64'd0, rd);
        check_val("t5_miss_data", rd, 64'd0);
        do_cmd("t5_misswr", wr_c, base_c + 40'h1_0000, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, rd);
        do_cmd("t5_s0rd", rd_c, base_c, 3'd3, 64'd0, rd);
        check_val("t5_s0_kept", rd, 64'h0BAD_F00D_1234_5678);
        check_val("t5_err_sticky", {63'd0, decode_err_o}, 64'd1);
        check_val("t5_finish_sticky", {63'd0, finish_o}, 64'd1);

        // 6: cycle counter spacing, then reset while a response is pending
        do_cmd("t6_c1", rd_c, base_c + 40'h3000, 3'd3, 64'd0, c1);
        repeat (8) @(negedge clk_i);
        do_cmd("t6_c2", rd_c, base_c + 40'h3000, 3'd3, 64'd0, c2);
        check_val("t6_delta", c2 - c1, 64'd10);
        io_cmd_type_i = rd_c;
        io_cmd_addr_i = base_c + 40'h3000;
        io_cmd_size_i = 3'd3;
        io_cmd_v_i    = 1'b1;
        @(negedge clk_i);
        io_cmd_v_i = 1'b0;
        check_val("t6_pending", {63'd0, io_resp_v_o}, 64'd1);
        reset_n_i = 1'b0;
        #1;
        check_val("t6_rst_resp_v", {63'd0, io_resp_v_o}, 64'd0);
        check_val("t6_rst_ready", {63'd0, io_cmd_ready_o}, 64'd0);
        check_val("t6_rst_flags", {61'd0, finish_o, decode_err_o, putchar_v_o}, 64'd0);
        check_val("t6_rst_code", {56'd0, finish_code_o}, 64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        do_cmd("t6_c3", rd_c, base_c + 40'h3000, 3'd3, 64'd0, rd);
        check_val("t6_cnt_after_rst", rd, 64'd1);
        do_cmd("t6_s0rd", rd_c, base_c, 3'd3, 64'd0, rd);
        check_val("t6_s0_cleared", rd, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
